// File: rtl/rho_calc.sv
// Hough vote coordinate: rho = x*cos(theta) + y*sin(theta), rounded to nearest.
// Inputs are registered at the sampling edge; lookup, multiply and add/round stages follow.
module rho_calc #(
    parameter int XY_W   = 12,
    parameter int FRAC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [XY_W-1:0] x,
    input  logic [XY_W-1:0] y,
    input  logic [31:0]     phase,
    output logic            out_vld,
    output logic [31:0]     rho_data
);

    localparam int TW = FRAC_W + 1;
    localparam int CW = FRAC_W + 2;
    localparam int PW = XY_W + FRAC_W + 2;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC_W - 1));

    // round(2^16 * sin(a deg)), a = 0..90
    localparam logic [TW-1:0] SIN_TAB [0:90] = '{
            0,  1144,  2287,  3430,  4572,  5712,  6850,  7987,  9121, 10252,
        11380, 12505, 13626, 14742, 15855, 16962, 18064, 19161, 20252, 21336,
        22415, 23486, 24550, 25607, 26656, 27697, 28729, 29753, 30767, 31772,
        32768, 33754, 34729, 35693, 36647, 37590, 38521, 39441, 40348, 41243,
        42126, 42995, 43852, 44695, 45525, 46341, 47143, 47930, 48703, 49461,
        50203, 50931, 51643, 52339, 53020, 53684, 54332, 54963, 55578, 56175,
        56756, 57319, 57865, 58393, 58903, 59396, 59870, 60326, 60764, 61183,
        61584, 61966, 62328, 62672, 62997, 63303, 63589, 63856, 64104, 64332,
        64540, 64729, 64898, 65048, 65177, 65287, 65376, 65446, 65496, 65526,
        65536
    };

    logic            v0, v1, v2;
    logic [XY_W-1:0] x0, y0, x1, y1;
    logic [1:0]      q0, q1;
    logic [6:0]      a0;
    logic [TW-1:0]   s1, c1;

    logic signed [CW-1:0] sp, cp, cos_v, sin_v;
    logic signed [PW-1:0] xe, ye, ce, se;
    logic signed [PW-1:0] px, py;
    logic signed [SW-1:0] sum, rnd, shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v0 <= in_vld;
            v1 <= v0;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        x0 <= x;
        y0 <= y;
        q0 <= phase[17:16];
        a0 <= (phase[6:0] > 7'd90) ? 7'd90 : phase[6:0];
        x1 <= x0;
        y1 <= y0;
        q1 <= q0;
        s1 <= SIN_TAB[a0];
        c1 <= SIN_TAB[7'd90 - a0];
        px <= xe * ce;
        py <= ye * se;
    end

    always_comb begin
        sp = {1'b0, s1};
        cp = {1'b0, c1};
        case (q1)
            2'd0:    begin cos_v =  cp; sin_v =  sp; end
            2'd1:    begin cos_v = -sp; sin_v =  cp; end
            2'd2:    begin cos_v = -cp; sin_v = -sp; end
            default: begin cos_v =  sp; sin_v = -cp; end
        endcase
        xe = {{(PW - XY_W){1'b0}}, x1};
        ye = {{(PW - XY_W){1'b0}}, y1};
        ce = {{(PW - CW){cos_v[CW-1]}}, cos_v};
        se = {{(PW - CW){sin_v[CW-1]}}, sin_v};
    end

    always_comb begin
        sum     = {px[PW-1], px} + {py[PW-1], py};
        rnd     = sum + HALF;
        shifted = rnd >>> FRAC_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            rho_data <= '0;
        end else begin
            out_vld <= v2;
            if (v2) begin
                rho_data <= {{(32 - SW){shifted[SW-1]}}, shifted};
            end
        end
    end

endmodule

// File: tb/tb_rho_calc.sv
// Directed bench for rho_calc: reset, angle coverage, throughput, hold, extremes, mid-stream reset.
module tb_rho_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [11:0] x;
    logic [11:0] y;
    logic [31:0] phase;
    logic        out_vld;
    logic [31:0] rho_data;

    int checks = 0;
    int errors = 0;

    rho_calc #(.XY_W(12), .FRAC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .x        (x),
        .y        (y),
        .phase    (phase),
        .out_vld  (out_vld),
        .rho_data (rho_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int q, input int a);
        return 32'((q << 16) | a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; x = 12'd100; y = 12'd100; phase = mk(0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) begin rst = 1'b0; in_vld = 1'b0; end
            checks++;
            if (out_vld !== 1'b0 || rho_data !== 32'd0) begin
                errors++;
                $display("FAIL reset[%0d]: out_vld=%b rho_data=%0d, required out_vld=0 rho_data=0",
                         i, out_vld, $signed(rho_data));
            end
        end
    endtask

    task automatic test_angles();
        logic [31:0] ph [12];
        int          ex [12];
        ph = '{mk(0,0), mk(0,30), mk(0,45), mk(0,60), mk(0,90), mk(1,45),
               mk(1,90), mk(2,0), mk(2,45), mk(3,0), mk(3,30), mk(3,45)};
        ex = '{100, 137, 141, 137, 100, 0, -100, -100, -141, -100, -37, 0};
        for (int i = 0; i < 12; i++) begin
            x = 12'd100; y = 12'd100; phase = ph[i]; in_vld = 1'b1;
            tick();
            in_vld = 1'b0;
            tick();
            tick();
            checks++;
            if (out_vld !== 1'b0) begin
                errors++;
                $display("FAIL angle[%0d] early: out_vld=%b, required 0", i, out_vld);
            end
            tick();
            checks++;
            if (out_vld !== 1'b1 || rho_data !== 32'(ex[i])) begin
                errors++;
                $display("FAIL angle[%0d]: out_vld=%b rho_data=%0d, required out_vld=1 rho_data=%0d",
                         i, out_vld, $signed(rho_data), ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ph [16];
        int          ex [16];
        ph = '{mk(0,0), mk(0,30), mk(0,45), mk(0,60), mk(0,90), mk(1,45), mk(1,90), mk(1,0),
               mk(2,0), mk(2,45), mk(2,90), mk(2,30), mk(3,30), mk(3,45), mk(3,0), mk(0,1)};
        ex = '{100, 137, 141, 137, 100, 0, -100, 100,
               -100, -141, -100, -137, -37, 0, -100, 102};
        for (int t = 0; t < 21; t++) begin
            if (t >= 1) begin
                checks++;
                if (t >= 4 && t < 20) begin
                    if (out_vld !== 1'b1 || rho_data !== 32'(ex[t-4])) begin
                        errors++;
                        $display("FAIL b2b[%0d]: out_vld=%b rho_data=%0d, required out_vld=1 rho_data=%0d",
                                 t - 4, out_vld, $signed(rho_data), ex[t-4]);
                    end
                end else if (out_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b idle t=%0d: out_vld=%b, required 0", t, out_vld);
                end
            end
            if (t < 16) begin
                x = 12'd100; y = 12'd100; phase = ph[t]; in_vld = 1'b1;
            end else begin
                in_vld = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_isolated();
        logic [31:0] ph [2];
        int          ex [2];
        ph = '{mk(0,30), mk(3,30)};
        ex = '{137, -37};
        for (int i = 0; i < 2; i++) begin
            x = 12'd100; y = 12'd100; phase = ph[i]; in_vld = 1'b1;
            tick();
            in_vld = 1'b0; phase = mk(1, 45);
            tick();
            tick();
            tick();
            checks++;
            if (out_vld !== 1'b1 || rho_data !== 32'(ex[i])) begin
                errors++;
                $display("FAIL isolated[%0d]: out_vld=%b rho_data=%0d, required out_vld=1 rho_data=%0d",
                         i, out_vld, $signed(rho_data), ex[i]);
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (out_vld !== 1'b0 || rho_data !== 32'(ex[i])) begin
                    errors++;
                    $display("FAIL hold[%0d.%0d]: out_vld=%b rho_data=%0d, required out_vld=0 rho_data=%0d",
                             i, k, out_vld, $signed(rho_data), ex[i]);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [11:0] xv [7];
        logic [11:0] yv [7];
        logic [31:0] ph [7];
        int          ex [7];
        xv = '{12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd100};
        yv = '{12'd4095, 12'd4095, 12'd0,    12'd7,    12'd7,    12'd0,    12'd100};
        ph = '{mk(0,45), mk(2,45), mk(1,90), 32'h0000_005F, mk(0,90), mk(0,1), 32'hA5A4_2A2D};
        ex = '{5791, -5791, -4095, 7, 7, 4094, 141};
        for (int i = 0; i < 7; i++) begin
            x = xv[i]; y = yv[i]; phase = ph[i]; in_vld = 1'b1;
            tick();
            in_vld = 1'b0;
            tick();
            tick();
            tick();
            checks++;
            if (out_vld !== 1'b1 || rho_data !== 32'(ex[i])) begin
                errors++;
                $display("FAIL extreme[%0d]: out_vld=%b rho_data=%0d, required out_vld=1 rho_data=%0d",
                         i, out_vld, $signed(rho_data), ex[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        tick();
        for (int t = 0; t < 9; t++) begin
            if (t >= 1 && t <= 7) begin
                checks++;
                if (out_vld !== 1'b0 || (t >= 3 && rho_data !== 32'd0)) begin
                    errors++;
                    $display("FAIL midrst t=%0d: out_vld=%b rho_data=%0d, required out_vld=0 rho_data=0",
                             t, out_vld, $signed(rho_data));
                end
            end
            if (t == 8) begin
                checks++;
                if (out_vld !== 1'b1 || rho_data !== 32'(-37)) begin
                    errors++;
                    $display("FAIL midrst new: out_vld=%b rho_data=%0d, required out_vld=1 rho_data=-37",
                             out_vld, $signed(rho_data));
                end
            end
            case (t)
                0: begin x = 12'd100; y = 12'd100; phase = mk(0, 45); in_vld = 1'b1; end
                1: begin phase = mk(0, 30); end
                2: begin phase = mk(0, 0); rst = 1'b1; end
                3: begin rst = 1'b0; in_vld = 1'b0; end
                4: begin phase = mk(3, 30); in_vld = 1'b1; end
                default: in_vld = 1'b0;
            endcase
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_angles();
        test_back_to_back();
        test_isolated();
        test_extremes();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rho_calc.md
# rho_calc

Hough-transform vote-coordinate calculator for the lane-detection datapath. For each valid request it takes an edge pixel (x, y) and a quadrant-encoded angle θ, and computes ρ = x·cos θ + y·sin θ. The result is a signed integer, rounded to nearest. The block is a fully pipelined stage between the edge-pixel/angle sequencer and the Hough accumulator address logic. It accepts one request per clock.

## Interface
Parameters:
- XY_W, 12: unsigned width of x and y.
- FRAC_W, 16: fractional bits of the internal sin/cos table; 1.0 = 2^FRAC_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high; clears the pipeline.
- in_vld  in  1  request strobe; x, y and phase are sampled on cycles where it is 1.
- x  in  XY_W  pixel column, unsigned.
- y  in  XY_W  pixel row, unsigned.
- phase  in  32  angle. phase[17:16] = quadrant q (0..3). phase[6:0] = offset a in degrees, 0..90. All other bits are ignored.
- out_vld  out  1  result strobe; one cycle per accepted request.
- rho_data  out  32  signed ρ in two's complement, sign-extended.

## Operation
- θ = 90·q + a degrees. a = 90 in quadrant q gives exactly the same result as a = 0 in quadrant q+1 (mod 4).
- Offset a in 91..127 saturates to 90.
- Table: 91 entries, S(a) = round(2^16·sin(a°)) for a = 0..90, unsigned 17-bit. Key values: S(0) = 0, S(30) = 32768, S(45) = 46341, S(60) = 56756, S(90) = 65536.
- C(a) = S(90−a). Use one table with two read ports, or two tables.
- Quadrant mapping, giving signed (cosθ, sinθ):
  - q = 0: (+C, +S)
  - q = 1: (−S, +C)
  - q = 2: (−C, −S)
  - q = 3: (+S, −C)
- Products: x·cosθ and y·sinθ. Each product is 12-bit unsigned × 18-bit signed, giving 30 bits signed. The sum is held at 31 bits signed with no overflow.
- Rounding: rho = (sum + 2^15) >>> 16, arithmetic shift (round half up). The result is sign-extended to 32 bits.
- No division and no iterative logic; table lookup plus multiply only.
- Requests are independent. Back-to-back in_vld is fully supported, with no stalls and no backpressure.

## Timing
- Pipeline latency is fixed at 3 cycles. A request sampled at edge N produces out_vld = 1 and a valid rho_data after edge N+3.
  - Stage 1: table lookup; register quadrant and x, y.
  - Stage 2: sign selection and multiplies.
  - Stage 3: add, round and register the output.
- out_vld is a delayed copy of in_vld through the 3-stage valid pipeline; it is high for exactly one cycle per request.
- rho_data holds its last valid value while out_vld = 0.
- Reset values: out_vld = 0, rho_data = 0, all internal valid bits = 0.
- Reset mid-operation:
  - In-flight requests are discarded and never produce out_vld.
  - in_vld asserted in the same cycle as rst is ignored.
  - The first request after rst deasserts follows normal latency.

## Test plan
- Reset: assert rst for 2 cycles while in_vld pulses -> out_vld = 0 and rho_data = 0 throughout, and for 3 cycles after release.
- Quadrant 0 sweep, x = y = 100 -> rho_data 100, 137, 141, 137, 100 for a = 0, 30, 45, 60, 90 respectively.
- Other quadrants, x = y = 100:
  - θ = 135 (q = 1, a = 45) -> 0.
  - θ = 180 (q = 1, a = 90) -> −100, equal to the result for q = 2, a = 0.
  - θ = 225 -> −141.
  - θ = 270 -> −100.
  - θ = 300 -> −37.
  - θ = 315 -> 0.
- Throughput and latency:
  - in_vld high for 16 consecutive cycles with θ stepping through the angles above -> 16 consecutive out_vld pulses, each exactly 3 cycles after its request, with results in order.
  - Isolated pulses -> rho_data held between pulses.
- Extremes:
  - x = y = 4095, θ = 45 -> 5791.
  - θ = 225 -> −5791.
  - x = 4095, y = 0, θ = 180 -> −4095.
  - phase = 0x0000_005F (a = 95) -> saturates, same result as a = 90.
- Mid-stream reset: 3 back-to-back requests, then rst after the 2nd accepted edge -> no out_vld for any of them. A new request issued 1 cycle after release returns at +3 cycles.
